// File: rtl/accelerator_vector_calculus_if.sv
// Handshake/data bundle for the streaming vector calculus engine.
// Ports: START/MODE_IN/SIZE_IN/LENGTH_IN op setup, READY idle flag,
//        DATA_IN_ENABLE/DATA_IN element in, DATA_ENABLE accept window,
//        DATA_OUT_ENABLE/DATA_OUT result out, OVERFLOW sticky clamp flag.
interface accelerator_vector_calculus_if #(
    parameter int DATA_SIZE  = 64,
    parameter int INDEX_SIZE = 16
);
    logic                  START;
    logic                  READY;
    logic                  MODE_IN;
    logic [INDEX_SIZE-1:0] SIZE_IN;
    logic [DATA_SIZE-1:0]  LENGTH_IN;
    logic                  DATA_IN_ENABLE;
    logic [DATA_SIZE-1:0]  DATA_IN;
    logic                  DATA_ENABLE;
    logic                  DATA_OUT_ENABLE;
    logic [DATA_SIZE-1:0]  DATA_OUT;
    logic                  OVERFLOW;

    modport master (
        output START, MODE_IN, SIZE_IN, LENGTH_IN,
        output DATA_IN_ENABLE, DATA_IN,
        input  READY, DATA_ENABLE, DATA_OUT_ENABLE,
        input  DATA_OUT, OVERFLOW
    );

    modport slave (
        input  START, MODE_IN, SIZE_IN, LENGTH_IN,
        input  DATA_IN_ENABLE, DATA_IN,
        output READY, DATA_ENABLE, DATA_OUT_ENABLE,
        output DATA_OUT, OVERFLOW
    );
endinterface

// File: rtl/accelerator_vector_calculus.sv
// Streaming vector engine: scaled forward difference (MODE_IN=0) or scaled
// running sum (MODE_IN=1) over a runtime-length signed vector.
// Ports: CLK, RST (async active-low), bus (slave modport of
//        accelerator_vector_calculus_if).
// Option: ACCELERATOR_CALCULUS_SATURATE_EN clamps difference, product and
//         accumulation and drives OVERFLOW; otherwise arithmetic wraps.
module accelerator_vector_calculus #(
    parameter int DATA_SIZE  = 64,
    parameter int INDEX_SIZE = 16
) (
    input logic                        CLK,
    input logic                        RST,
    accelerator_vector_calculus_if.slave bus
);
    localparam int W = DATA_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [INDEX_SIZE-1:0] cnt_q, cnt_d;
    logic [INDEX_SIZE-1:0] size_q;
    logic                  mode_q;
    logic [W-1:0]          k_q;
    logic [W-1:0]          prev_q;
    logic [W-1:0]          acc_q;
    logic [W-1:0]          dout_q;
    logic                  doe_q;

    logic                  start_ok;
    logic                  accept;
    logic                  last_elem;

    logic [W-1:0]          diff_v;
    logic [W-1:0]          op_v;
    logic [W-1:0]          prod_v;
    logic [W-1:0]          sum_v;
    logic [W-1:0]          y_v;

    assign start_ok  = (state_q == IDLE) && bus.START;
    assign accept    = (state_q == RUN) && bus.DATA_IN_ENABLE;
    assign last_elem = (cnt_q == size_q - INDEX_SIZE'(1));

    // FSM next state and element counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    cnt_d   = '0;
                    state_d = (bus.SIZE_IN == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus.DATA_IN_ENABLE) begin
                    cnt_d = cnt_q + INDEX_SIZE'(1);
                    if (last_elem) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef ACCELERATOR_CALCULUS_SATURATE_EN
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    logic signed [W:0]     diff_w;
    logic signed [2*W-1:0] prod_w;
    logic signed [W:0]     sum_w;
    logic                  diff_ov;
    logic                  prod_ov;
    logic                  sum_ov;
    logic                  flag_v;
    logic                  ovf_q;

    // One guard bit is enough for the add/subtract; the product needs the
    // full double width so any bit above the sign position can be checked.
    always_comb begin
        diff_w  = $signed({bus.DATA_IN[W-1], bus.DATA_IN})
                - $signed({prev_q[W-1], prev_q});
        diff_ov = diff_w[W] ^ diff_w[W-1];
        diff_v  = diff_ov ? (diff_w[W] ? SMIN : SMAX) : diff_w[W-1:0];

        op_v    = mode_q ? bus.DATA_IN : diff_v;
        prod_w  = $signed(op_v) * $signed(k_q);
        prod_ov = !((&prod_w[2*W-1:W-1]) || !(|prod_w[2*W-1:W-1]));
        prod_v  = prod_ov ? (prod_w[2*W-1] ? SMIN : SMAX)
                          : prod_w[W-1:0];

        sum_w   = $signed({acc_q[W-1], acc_q})
                + $signed({prod_v[W-1], prod_v});
        sum_ov  = sum_w[W] ^ sum_w[W-1];
        sum_v   = sum_ov ? (sum_w[W] ? SMIN : SMAX) : sum_w[W-1:0];

        // Element 0 of a difference is forced to 0, so its clamps are moot.
        if (mode_q) flag_v = prod_ov | sum_ov;
        else        flag_v = (cnt_q != '0) && (diff_ov | prod_ov);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_q <= 1'b0;
        end else if (start_ok) begin
            ovf_q <= 1'b0;
        end else if (accept && flag_v) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.OVERFLOW = ovf_q;
`else
    always_comb begin
        diff_v = bus.DATA_IN - prev_q;
        op_v   = mode_q ? bus.DATA_IN : diff_v;
        prod_v = op_v * k_q;
        sum_v  = acc_q + prod_v;
    end

    assign bus.OVERFLOW = 1'b0;
`endif

    always_comb begin
        y_v = '0;
        if (mode_q)              y_v = sum_v;
        else if (cnt_q != '0)    y_v = prod_v;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            size_q  <= '0;
            mode_q  <= 1'b0;
            k_q     <= '0;
            prev_q  <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            doe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            doe_q   <= accept;
            if (start_ok) begin
                mode_q <= bus.MODE_IN;
                size_q <= bus.SIZE_IN;
                k_q    <= bus.LENGTH_IN;
                prev_q <= '0;
                acc_q  <= '0;
            end
            if (accept) begin
                prev_q <= bus.DATA_IN;
                acc_q  <= sum_v;
                dout_q <= y_v;
            end
        end
    end

    assign bus.READY           = (state_q == IDLE);
    assign bus.DATA_ENABLE     = (state_q == RUN);
    assign bus.DATA_OUT_ENABLE = doe_q;
    assign bus.DATA_OUT        = dout_q;
endmodule

// File: tb/tb_accelerator_vector_calculus.sv
// Directed bench for accelerator_vector_calculus.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_accelerator_vector_calculus;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    accelerator_vector_calculus_if #(.DATA_SIZE(64), .INDEX_SIZE(16)) bus ();

    accelerator_vector_calculus #(.DATA_SIZE(64), .INDEX_SIZE(16)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic mode, input logic [15:0] n,
                         input logic [63:0] k);
        bus.START     = 1'b1;
        bus.MODE_IN   = mode;
        bus.SIZE_IN   = n;
        bus.LENGTH_IN = k;
        tick();
        bus.START = 1'b0;
        chk("ready_low_after_start", 64'(bus.READY), 64'd0);
    endtask

    task automatic feed(input string tag, input logic [63:0] x,
                        input logic [63:0] y);
        bus.DATA_IN_ENABLE = 1'b1;
        bus.DATA_IN        = x;
        tick();
        bus.DATA_IN_ENABLE = 1'b0;
        chk({tag, "_doe"}, 64'(bus.DATA_OUT_ENABLE), 64'd1);
        chk(tag, bus.DATA_OUT, y);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.START          = 1'b0;
        bus.MODE_IN        = 1'b0;
        bus.SIZE_IN        = '0;
        bus.LENGTH_IN      = '0;
        bus.DATA_IN_ENABLE = 1'b0;
        bus.DATA_IN        = '0;
        tick();
        tick();
        chk("rst_ready", 64'(bus.READY), 64'd1);
        chk("rst_den", 64'(bus.DATA_ENABLE), 64'd0);
        chk("rst_doe", 64'(bus.DATA_OUT_ENABLE), 64'd0);
        chk("rst_dout", bus.DATA_OUT, 64'd0);
        chk("rst_ovf", 64'(bus.OVERFLOW), 64'd0);
        rst_n = 1'b1;
        tick();

        // Differentiation N=4 k=2 x={5,9,4,4}
        start(1'b0, 16'd4, 64'd2);
        chk("diff_den", 64'(bus.DATA_ENABLE), 64'd1);
        feed("diff_y0", 64'd5, 64'd0);
        feed("diff_y1", 64'd9, 64'd8);
        feed("diff_y2", 64'd4, -64'sd10);
        feed("diff_y3", 64'd4, 64'd0);
        chk("diff_ready_t1", 64'(bus.READY), 64'd0);
        tick();
        chk("diff_ready_t2", 64'(bus.READY), 64'd1);
        chk("diff_doe_t2", 64'(bus.DATA_OUT_ENABLE), 64'd0);
        chk("diff_hold", bus.DATA_OUT, 64'd0);

        // Integration N=3 k=3 x={1,2,-4}, gap before last
        start(1'b1, 16'd3, 64'd3);
        feed("int_y0", 64'd1, 64'd3);
        feed("int_y1", 64'd2, 64'd9);
        tick();
        chk("int_gap_doe", 64'(bus.DATA_OUT_ENABLE), 64'd0);
        chk("int_gap_hold", bus.DATA_OUT, 64'd9);
        chk("int_gap_den", 64'(bus.DATA_ENABLE), 64'd1);
        feed("int_y2", -64'sd4, -64'sd3);
        tick();
        chk("int_ready", 64'(bus.READY), 64'd1);

        // SIZE_IN=0
        start(1'b0, 16'd0, 64'd1);
        chk("zero_doe1", 64'(bus.DATA_OUT_ENABLE), 64'd0);
        chk("zero_den", 64'(bus.DATA_ENABLE), 64'd0);
        tick();
        chk("zero_doe2", 64'(bus.DATA_OUT_ENABLE), 64'd0);
        chk("zero_ready", 64'(bus.READY), 64'd1);

        // START during RUN ignored: N=2 k=1 diff must stay in force
        start(1'b0, 16'd2, 64'd1);
        feed("ign_y0", 64'd3, 64'd0);
        bus.START     = 1'b1;
        bus.MODE_IN   = 1'b1;
        bus.SIZE_IN   = 16'd5;
        bus.LENGTH_IN = 64'd100;
        feed("ign_y1", 64'd10, 64'd7);
        bus.START = 1'b0;
        chk("ign_done", 64'(bus.DATA_ENABLE), 64'd0);
        tick();
        chk("ign_ready", 64'(bus.READY), 64'd1);

        // DATA_IN_ENABLE in IDLE
        bus.DATA_IN_ENABLE = 1'b1;
        bus.DATA_IN        = 64'd55;
        tick();
        bus.DATA_IN_ENABLE = 1'b0;
        chk("idle_doe", 64'(bus.DATA_OUT_ENABLE), 64'd0);
        chk("idle_hold", bus.DATA_OUT, 64'd7);

        // Reset mid-vector
        start(1'b1, 16'd5, 64'd1);
        feed("rstm_y0", 64'd1, 64'd1);
        feed("rstm_y1", 64'd2, 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstm_ready", 64'(bus.READY), 64'd1);
        chk("rstm_den", 64'(bus.DATA_ENABLE), 64'd0);
        chk("rstm_doe", 64'(bus.DATA_OUT_ENABLE), 64'd0);
        chk("rstm_dout", bus.DATA_OUT, 64'd0);
        chk("rstm_ovf", 64'(bus.OVERFLOW), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start(1'b1, 16'd2, 64'd1);
        feed("fresh_y0", 64'd7, 64'd7);
        feed("fresh_y1", 64'd1, 64'd8);
        tick();

        // Integration overflow
        start(1'b1, 16'd2, 64'd1);
        feed("ovf_y0", 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
        chk("ovf_flag0", 64'(bus.OVERFLOW), 64'd0);
`ifdef ACCELERATOR_CALCULUS_SATURATE_EN
        feed("ovf_y1", 64'h4000_0000_0000_0000, 64'h7fff_ffff_ffff_ffff);
        chk("ovf_flag1", 64'(bus.OVERFLOW), 64'd1);
`else
        feed("ovf_y1", 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000);
        chk("ovf_flag1", 64'(bus.OVERFLOW), 64'd0);
`endif
        tick();

        // Back-to-back at earliest READY
        start(1'b0, 16'd2, 64'd1);
        feed("b2b_d0", 64'd3, 64'd0);
        feed("b2b_d1", 64'd1, -64'sd2);
        tick();
        chk("b2b_ready", 64'(bus.READY), 64'd1);
        start(1'b1, 16'd2, 64'd1);
        chk("b2b_ovf_clr", 64'(bus.OVERFLOW), 64'd0);
        feed("b2b_i0", 64'd3, 64'd3);
        feed("b2b_i1", 64'd1, 64'd4);
        tick();
        chk("b2b_ready2", 64'(bus.READY), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
